// File: rtl/wr_pack_fsm.sv
// wr_pack_fsm: packs IN_W-bit FIFO beats MSB-first into OUT_W-bit words.
// Words are presented on a valid/ready handshake with a beat count.
// i_flush emits a right-aligned partial word.
// The FIFO has a one-cycle read latency: data arrives the cycle after read_en.
// Optional build macro WR_PACK_DBG_CNT_EN adds two debug counters:
//   dbg_rd_cnt   - FIFO reads
//   dbg_word_cnt - accepted words
// OUT_W must be an integer multiple of IN_W.
// BEATS and CNT_W are derived from the widths and are not meant to be overridden.
module wr_pack_fsm #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 256,
    parameter int BEATS = OUT_W / IN_W,
    parameter int CNT_W = $clog2(BEATS + 1)
) (
    input  logic             axi_clk,
    input  logic             rst,
    input  logic             fifo_empty,
    output logic             read_en,
    input  logic [IN_W-1:0]  i_data,
    input  logic             i_flush,
    output logic [OUT_W-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [CNT_W-1:0] o_beats,
    output logic             o_partial,
    output logic             busy
`ifdef WR_PACK_DBG_CNT_EN
    ,
    output logic [15:0]      dbg_rd_cnt,
    output logic [15:0]      dbg_word_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_CAP  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [OUT_W-1:0]   r_shreg;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_read_en;
    logic [OUT_W-1:0]   r_o_data;
    logic               r_o_valid;
    logic [CNT_W-1:0]   r_o_beats;
    logic               r_o_partial;

    logic [OUT_W-1:0]   w_shift;
    logic               w_cnt_full;
    logic               w_cnt_zero;
    logic               w_rd_nxt;
    logic               w_load;
    logic               w_cap;
    logic               w_accept;

    assign w_cnt_full = (r_cnt == CNT_W'(BEATS));
    assign w_cnt_zero = (r_cnt == '0);

    // New beat enters at the bottom.
    // After BEATS shifts, the first beat sits in the MSBs.
    generate
        if (BEATS == 1) begin : g_single
            assign w_shift = i_data;
        end else begin : g_multi
            assign w_shift = {r_shreg[OUT_W-IN_W-1:0], i_data};
        end
    endgenerate

    // State register
    always_ff @(posedge axi_clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic.
    // A full word wins first, then FIFO data, then a flush of a non-empty partial word.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cnt_full)                  w_next = S_OUT;
                else if (!fifo_empty)            w_next = S_REQ;
                else if (i_flush && !w_cnt_zero) w_next = S_OUT;
                else                             w_next = S_IDLE;
            end
            S_REQ:   w_next = S_CAP;
            S_CAP:   w_next = S_IDLE;
            S_OUT:   if (r_o_valid && i_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode.
    // These strobes drive the registered datapath below.
    always_comb begin
        w_rd_nxt = (w_next == S_REQ);
        w_load   = (r_state != S_OUT) && (w_next == S_OUT);
        w_cap    = (r_state == S_CAP);
        w_accept = (r_state == S_OUT) && r_o_valid && i_ready;
    end

    // read_en is registered.
    // It is high for exactly the REQ cycle, which is always followed by CAP.
    always_ff @(posedge axi_clk or negedge rst) begin
        if (!rst) r_read_en <= 1'b0;
        else      r_read_en <= w_rd_nxt;
    end

    // Shift register and beat counter.
    // Both clear once the consumer takes the word.
    always_ff @(posedge axi_clk or negedge rst) begin
        if (!rst) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (w_cap) begin
            r_shreg <= w_shift;
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // Output word registers.
    // They are loaded on entry to OUT and held until the handshake.
    always_ff @(posedge axi_clk or negedge rst) begin
        if (!rst) begin
            r_o_data    <= '0;
            r_o_valid   <= 1'b0;
            r_o_beats   <= '0;
            r_o_partial <= 1'b0;
        end else if (w_load) begin
            r_o_data    <= r_shreg;
            r_o_valid   <= 1'b1;
            r_o_beats   <= r_cnt;
            r_o_partial <= !w_cnt_full;
        end else if (w_accept) begin
            r_o_valid   <= 1'b0;
        end
    end

    assign read_en   = r_read_en;
    assign o_data    = r_o_data;
    assign o_valid   = r_o_valid;
    assign o_beats   = r_o_beats;
    assign o_partial = r_o_partial;
    assign busy      = (r_state != S_IDLE) || !w_cnt_zero;

`ifdef WR_PACK_DBG_CNT_EN
    logic [15:0] r_dbg_rd;
    logic [15:0] r_dbg_word;

    // Free-running debug counters that wrap at 16 bits
    always_ff @(posedge axi_clk or negedge rst) begin
        if (!rst) begin
            r_dbg_rd   <= '0;
            r_dbg_word <= '0;
        end else begin
            if (r_read_en) r_dbg_rd   <= r_dbg_rd + 16'd1;
            if (w_accept)  r_dbg_word <= r_dbg_word + 16'd1;
        end
    end

    assign dbg_rd_cnt   = r_dbg_rd;
    assign dbg_word_cnt = r_dbg_word;
`endif

endmodule
